// File: rtl/dot_matrix.sv
// Row-scanned driver for an 8x8 red/green LED matrix showing two dice faces.
// Live mode shows the incoming dice in red; a stop edge freezes them in green (yellow on a double).
module dot_matrix #(
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop,
    input  logic [3:0] dice1,
    input  logic [3:0] dice2,
    output logic [7:0] row,
    output logic [7:0] r_col,
    output logic [7:0] g_col
);

    localparam int unsigned    DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic MODE_LIVE   = 1'b0;
    localparam logic MODE_FROZEN = 1'b1;

    logic [2:0]       scan_idx;
    logic [DIV_W-1:0] div_cnt;
    logic             mode;
    logic [3:0]       held1, held2;
    logic             stop_d;

    logic [3:0] face1, face2;
    logic [1:0] pip_sel;
    logic [7:0] pixels;
    logic       stop_rise, red_on, green_on;

    // Returns {L, C, R} pips of one face for pip row pr (0 = top, 1 = middle, 2 = bottom).
    function automatic logic [2:0] pip_row(input logic [3:0] v, input logic [1:0] pr);
        case (v)
            4'd1:    pip_row = (pr == 2'd1) ? 3'b010 : 3'b000;
            4'd2:    pip_row = (pr == 2'd0) ? 3'b100 : (pr == 2'd2) ? 3'b001 : 3'b000;
            4'd3:    pip_row = (pr == 2'd0) ? 3'b100 : (pr == 2'd1) ? 3'b010 : 3'b001;
            4'd4:    pip_row = (pr == 2'd1) ? 3'b000 : 3'b101;
            4'd5:    pip_row = (pr == 2'd1) ? 3'b010 : 3'b101;
            4'd6:    pip_row = 3'b101;
            default: pip_row = 3'b000;
        endcase
    endfunction

    always_comb begin
        face1     = (mode == MODE_FROZEN) ? held1 : dice1;
        face2     = (mode == MODE_FROZEN) ? held2 : dice2;
        pip_sel   = 2'(scan_idx - 3'd2);
        pixels    = 8'h00;
        if (scan_idx >= 3'd2 && scan_idx <= 3'd4) begin
            pixels = {1'b0, pip_row(face1, pip_sel), 1'b0, pip_row(face2, pip_sel)};
        end
        // A frozen double lights both colours; blank out-of-range faces stay dark anyway.
        red_on    = (mode == MODE_LIVE) || (held1 == held2);
        green_on  = (mode == MODE_FROZEN);
        stop_rise = stop & ~stop_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx <= 3'd0;
            div_cnt  <= '0;
            mode     <= MODE_LIVE;
            held1    <= 4'd0;
            held2    <= 4'd0;
            stop_d   <= 1'b0;
            row      <= 8'hFF;
            r_col    <= 8'h00;
            g_col    <= 8'h00;
        end else begin
            stop_d <= stop;
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            row   <= ~(8'h01 << scan_idx);
            r_col <= red_on ? pixels : 8'h00;
            g_col <= green_on ? pixels : 8'h00;
            if (stop_rise) begin
                mode <= ~mode;
                if (mode == MODE_LIVE) begin
                    held1 <= dice1;
                    held2 <= dice2;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_matrix.sv
// Self-checking bench for dot_matrix: two instances (SCAN_DIV 1 and 4) against a behavioural model.
module tb_dot_matrix;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] dice1 = 4'd0;
    logic [3:0] dice2 = 4'd0;
    logic [7:0] row_a, r_a, g_a, row_b, r_b, g_b;

    int errors = 0;
    int checks = 0;
    int cyc;
    bit cmp_en = 1'b0;

    dot_matrix #(.SCAN_DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .stop(stop), .dice1(dice1), .dice2(dice2),
        .row(row_a), .r_col(r_a), .g_col(g_a)
    );

    dot_matrix #(.SCAN_DIV(4)) u_dut_b (
        .clk(clk), .rst(rst), .stop(stop), .dice1(dice1), .dice2(dice2),
        .row(row_b), .r_col(r_b), .g_col(g_b)
    );

    always #5 clk = ~clk;

    // Model state: clocks since reset, mode, held faces, previous stop.
    int         n;
    bit         live;
    logic [3:0] h1, h2;
    logic       pstop;
    logic [7:0] exp_row_a, exp_r_a, exp_g_a, exp_row_b, exp_r_b, exp_g_b;

    // Face as a 3x3 grid: {top L,C,R, mid L,C,R, bottom L,C,R}.
    function automatic logic [8:0] face(input logic [3:0] v);
        case (v)
            4'd1:    return 9'b000_010_000;
            4'd2:    return 9'b100_000_001;
            4'd3:    return 9'b100_010_001;
            4'd4:    return 9'b101_000_101;
            4'd5:    return 9'b101_010_101;
            4'd6:    return 9'b101_101_101;
            default: return 9'b000_000_000;
        endcase
    endfunction

    function automatic logic [7:0] pix(input logic [3:0] a, input logic [3:0] b, input int r);
        logic [8:0] fa, fb;
        fa = face(a);
        fb = face(b);
        case (r)
            2:       return {1'b0, fa[8:6], 1'b0, fb[8:6]};
            3:       return {1'b0, fa[5:3], 1'b0, fb[5:3]};
            4:       return {1'b0, fa[2:0], 1'b0, fb[2:0]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] want_red(input int r);
        if (live) return pix(dice1, dice2, r);
        if (h1 == h2) return pix(h1, h2, r);
        return 8'h00;
    endfunction

    function automatic logic [7:0] want_green(input int r);
        if (live) return 8'h00;
        return pix(h1, h2, r);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n         <= 0;
            live      <= 1'b1;
            h1        <= 4'd0;
            h2        <= 4'd0;
            pstop     <= 1'b0;
            exp_row_a <= 8'hFF;
            exp_r_a   <= 8'h00;
            exp_g_a   <= 8'h00;
            exp_row_b <= 8'hFF;
            exp_r_b   <= 8'h00;
            exp_g_b   <= 8'h00;
        end else begin
            exp_row_a <= ~(8'h01 << (n % 8));
            exp_r_a   <= want_red(n % 8);
            exp_g_a   <= want_green(n % 8);
            exp_row_b <= ~(8'h01 << ((n / 4) % 8));
            exp_r_b   <= want_red((n / 4) % 8);
            exp_g_b   <= want_green((n / 4) % 8);
            n         <= n + 1;
            pstop     <= stop;
            if (stop && !pstop) begin
                live <= !live;
                if (live) begin
                    h1 <= dice1;
                    h2 <= dice2;
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model row a", row_a, exp_row_a);
            check("model r_col a", r_a, exp_r_a);
            check("model g_col a", g_a, exp_g_a);
            check("model row b", row_b, exp_row_b);
            check("model r_col b", r_b, exp_r_b);
            check("model g_col b", g_b, exp_g_b);
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Asserts reset mid-cycle, checks the immediate blank, releases just after a falling edge.
    task automatic do_reset(input logic [3:0] d1, input logic [3:0] d2, input logic s);
        rst   = 1'b1;
        dice1 = d1;
        dice2 = d2;
        stop  = s;
        #1;
        check("reset row a", row_a, 8'hFF);
        check("reset r_col a", r_a, 8'h00);
        check("reset g_col a", g_a, 8'h00);
        check("reset row b", row_b, 8'hFF);
        check("reset r_col b", r_b, 8'h00);
        check("reset g_col b", g_b, 8'h00);
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        cyc = -1;
    endtask

    logic [7:0] tbl_12[8]     = '{8'h00, 8'h00, 8'h04, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00};
    logic [7:0] tbl_67[8]     = '{8'h00, 8'h00, 8'h50, 8'h50, 8'h50, 8'h00, 8'h00, 8'h00};
    logic [7:0] tbl_35[8]     = '{8'h00, 8'h00, 8'h45, 8'h22, 8'h15, 8'h00, 8'h00, 8'h00};
    logic [7:0] tbl_44[8]     = '{8'h00, 8'h00, 8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00};
    logic [7:0] tbl_23[8]     = '{8'h00, 8'h00, 8'h44, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00};

    initial begin
        #1;
        // Live 1/2 in red; also pins the row sequence of both scan rates.
        do_reset(4'd1, 4'd2, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("live12 row a", row_a, ~(8'h01 << (cyc % 8)));
            check("live12 red a", r_a, tbl_12[cyc % 8]);
            check("live12 green a", g_a, 8'h00);
            check("div4 row b", row_b, ~(8'h01 << (cyc / 4)));
            check("live12 red b", r_b, tbl_12[cyc / 4]);
        end

        // Live 6/7: out-of-range right die is blank; then 0/0 blanks everything.
        do_reset(4'd6, 4'd7, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("live67 red a", r_a, tbl_67[cyc % 8]);
        end
        #1;
        dice1 = 4'd0;
        dice2 = 4'd0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("live00 red a", r_a, 8'h00);
            check("live00 green a", g_a, 8'h00);
        end

        // Freeze 3/5 in green, inputs change underneath, then unfreeze.
        do_reset(4'd3, 4'd5, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (cyc > 0) begin
                check("frozen35 green a", g_a, tbl_35[cyc % 8]);
                check("frozen35 red a", r_a, 8'h00);
            end
            #1;
            stop  = 1'b0;
            dice1 = 4'd8;
            dice2 = 4'd9;
        end
        stop = 1'b1;
        tick();
        #1;
        stop = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("live89 red a", r_a, 8'h00);
            check("live89 green a", g_a, 8'h00);
        end
        #1;
        dice1 = 4'd1;
        dice2 = 4'd2;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("relive12 red a", r_a, tbl_12[cyc % 8]);
        end

        // Frozen double 4/4 shows yellow.
        do_reset(4'd4, 4'd4, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cyc > 0) begin
                check("yellow red a", r_a, tbl_44[cyc % 8]);
                check("yellow green a", g_a, tbl_44[cyc % 8]);
            end
            #1;
            stop = 1'b0;
        end

        // Stop held high for 10 cycles toggles exactly once.
        do_reset(4'd2, 4'd3, 1'b0);
        tick();
        tick();
        #1;
        stop = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        #1;
        stop = 1'b0;
        while (cyc < 16) tick();
        while (cyc < 48) begin
            check("held stop green b", g_b, tbl_23[(cyc / 4) % 8]);
            check("held stop red b", r_b, 8'h00);
            check("held stop green a", g_a, tbl_23[cyc % 8]);
            tick();
        end

        // Randomized traffic against the model, with occasional async resets.
        do_reset(4'($urandom_range(1, 6)), 4'($urandom_range(1, 6)), 1'b0);
        for (int k = 0; k < 4000; k++) begin
            tick();
            #1;
            if ($urandom_range(0, 3) == 0) begin
                dice1 = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(1, 6));
                dice2 = ($urandom_range(0, 3) == 0) ? dice1 : 4'($urandom_range(1, 6));
            end
            if ($urandom_range(0, 9) == 0) stop = ~stop;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(dice1, dice2, stop);
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
